// File: rtl/sequencer_for_tdc_v1_sw_28_10_19_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_seq_pkg
// Description : Shared types and constants for the TDC_V1 test-setup
//               sequencer: state encoding, RAM word tags, window length and
//               the DOUT word packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_seq_pkg;

  // Run phases, in the order a run walks through them.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LATCH   = 3'd3,
    ST_READ    = 3'd4,
    ST_SAFF_LO = 3'd5,
    ST_SAFF_HI = 3'd6
  } state_e;

  // Length of the PSTART/PSTOP measure window in clock cycles.
  localparam int MEASURE_CYCLES = 256;

  // Tags in the top bits of each RAM word identify the word type.
  localparam logic       TAG_DOUT    = 1'b0;
  localparam logic [1:0] TAG_SAFF_LO = 2'b10;
  localparam logic [1:0] TAG_SAFF_HI = 2'b11;

  // Readout word: tag, SEL value, four spare zeros, then the 7-bit DOUT.
  function automatic logic [15:0] dout_word(input logic [3:0] sel, input logic [6:0] dout);
    return {TAG_DOUT, sel, 4'b0000, dout};
  endfunction

  // Low SAFF word carries bits 13:0.
  function automatic logic [15:0] saff_lo_word(input logic [20:0] saff);
    return {TAG_SAFF_LO, saff[13:0]};
  endfunction

  // High SAFF word carries bits 20:14, zero padded.
  function automatic logic [15:0] saff_hi_word(input logic [20:0] saff);
    return {TAG_SAFF_HI, 7'b0000000, saff[20:14]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sequencer_for_tdc_v1_sw_28_10_19_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pulse_gen
// Description : Measure-window counter with PSTART/PSTOP compare-and-hold.
//               The counter runs 0..255 while the window is open; each pulse
//               rises on the cycle its threshold is reached and holds until
//               the window closes.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_pulse_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       win_now_i,    // window open in the current cycle
  input  logic       win_next_i,   // window open in the next cycle
  input  logic [7:0] t_start_i,
  input  logic [7:0] t_stop_i,
  output logic [7:0] count_o,
  output logic       pstart_o,
  output logic       pstop_o
);

  logic [7:0] count_q, count_d;
  logic       pstart_q, pstart_d;
  logic       pstop_q, pstop_d;

  // Next count restarts at 0 on window entry; pulses compare against the
  // count of the coming cycle so the registered outputs line up with it.
  always_comb begin
    count_d  = 8'd0;
    pstart_d = 1'b0;
    pstop_d  = 1'b0;
    if (win_next_i) begin
      count_d  = win_now_i ? (count_q + 8'd1) : 8'd0;
      pstart_d = (win_now_i & pstart_q) | (count_d == t_start_i);
      pstop_d  = (win_now_i & pstop_q)  | (count_d == t_stop_i);
    end
  end

  // Window counter and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 8'd0;
      pstart_q <= 1'b0;
      pstop_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      pstart_q <= pstart_d;
      pstop_q  <= pstop_d;
    end
  end

  assign count_o  = count_q;
  assign pstart_o = pstart_q;
  assign pstop_o  = pstop_q;

endmodule
`default_nettype wire

// File: rtl/sequencer_for_tdc_v1_sw_28_10_19.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_for_tdc_v1_sw_28_10_19
// Description : Run sequencer for the TDC_V1 chip. Resets the chip, fires
//               PSTART/PSTOP inside a 256-cycle window, latches SAFF, scans
//               DOUT over all SEL values and streams 18 tagged words out.
// Revision    : 1.0 - initial release
// ============================================================================
module sequencer_for_tdc_v1_sw_28_10_19
  import tdc_seq_pkg::*;
#(
  parameter int RES_CYCLES    = 4,
  parameter int NUM_SEL       = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_sequencer,
  input  logic [7:0]  t_start_coarse,
  input  logic [7:0]  t_stop_coarse,
  output logic        ready_flag,
  output logic        measure_flag,
  output logic        write,
  output logic [15:0] data,
  output logic [3:0]  SEL,
  output logic        PSTART,
  output logic        PSTOP,
  output logic        RES,
  input  logic [6:0]  DOUT,
  input  logic [20:0] SAFF
);

  localparam logic [7:0] C_RES_LAST    = 8'(RES_CYCLES - 1);
  localparam logic [7:0] C_SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [3:0] C_SEL_LAST    = 4'(NUM_SEL - 1);
  localparam logic [7:0] C_WIN_LAST    = 8'(MEASURE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;        // RESET length / READ settle+write phase
  logic [3:0]  k_q, k_d;            // SEL value being read out
  logic [7:0]  tstart_q, tstart_d;
  logic [7:0]  tstop_q, tstop_d;
  logic [20:0] saff_q;

  logic        ready_q, ready_d;
  logic        meas_q, meas_d;
  logic        res_q, res_d;
  logic        write_q, write_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  sel_q, sel_d;

  logic [7:0]  win_count;
  logic        win_now, win_next;

  assign win_now  = (state_q == ST_MEASURE);
  assign win_next = (state_d == ST_MEASURE);

  tdc_pulse_gen u_pulse_gen (
    .clk        (clk),
    .reset      (reset),
    .win_now_i  (win_now),
    .win_next_i (win_next),
    .t_start_i  (tstart_q),
    .t_stop_i   (tstop_q),
    .count_o    (win_count),
    .pstart_o   (PSTART),
    .pstop_o    (PSTOP)
  );

  // Next-state, counters and run-parameter capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    tstart_d = tstart_q;
    tstop_d  = tstop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_sequencer) begin
          state_d  = ST_RESET;
          cnt_d    = 8'd0;
          tstart_d = t_start_coarse;
          tstop_d  = t_stop_coarse;
        end
      end
      ST_RESET: begin
        if (cnt_q == C_RES_LAST) begin
          state_d = ST_MEASURE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_MEASURE: begin
        if (win_count == C_WIN_LAST) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d = ST_READ;
        cnt_d   = 8'd0;
        k_d     = 4'd0;
      end
      ST_READ: begin
        // Phases 0..SETTLE-1 settle, phase SETTLE is the write cycle.
        if (cnt_q == C_SETTLE_LAST) begin
          cnt_d = 8'd0;
          if (k_q == C_SEL_LAST) state_d = ST_SAFF_LO;
          else                   k_d     = k_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAFF_LO: state_d = ST_SAFF_HI;
      ST_SAFF_HI: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the
  // registered pins line up exactly with the phase they belong to.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    meas_d  = (state_d == ST_MEASURE);
    res_d   = (state_d == ST_RESET);
    sel_d   = (state_d == ST_READ) ? k_d : 4'd0;
    write_d = 1'b0;
    data_d  = data_q;
    if ((state_d == ST_READ) && (cnt_d == C_SETTLE_LAST)) begin
      write_d = 1'b1;
      data_d  = dout_word(k_d, DOUT);
    end else if (state_d == ST_SAFF_LO) begin
      write_d = 1'b1;
      data_d  = saff_lo_word(saff_q);
    end else if (state_d == ST_SAFF_HI) begin
      write_d = 1'b1;
      data_d  = saff_hi_word(saff_q);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Counters, captured thresholds and the SAFF snapshot taken in LATCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 8'd0;
      k_q      <= 4'd0;
      tstart_q <= 8'd0;
      tstop_q  <= 8'd0;
      saff_q   <= 21'd0;
    end else begin
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      tstart_q <= tstart_d;
      tstop_q  <= tstop_d;
      if (state_q == ST_LATCH) saff_q <= SAFF;
    end
  end

  // Registered output pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b1;
      meas_q  <= 1'b0;
      res_q   <= 1'b0;
      write_q <= 1'b0;
      data_q  <= 16'd0;
      sel_q   <= 4'd0;
    end else begin
      ready_q <= ready_d;
      meas_q  <= meas_d;
      res_q   <= res_d;
      write_q <= write_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign ready_flag   = ready_q;
  assign measure_flag = meas_q;
  assign RES          = res_q;
  assign write        = write_q;
  assign data         = data_q;
  assign SEL          = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_sequencer_for_tdc_v1_sw_28_10_19.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequencer_for_tdc_v1_sw_28_10_19
// Description : Self-checking bench; a cycle-index model of one run is
//               compared against every DUT output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequencer_for_tdc_v1_sw_28_10_19;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_sequencer = 1'b0;
  logic [7:0]  t_start_coarse = 8'd0;
  logic [7:0]  t_stop_coarse = 8'd0;
  logic [6:0]  DOUT;
  logic [20:0] SAFF;
  logic        ready_flag, measure_flag, write, PSTART, PSTOP, RES;
  logic [15:0] data;
  logic [3:0]  SEL;

  int errors = 0;
  int checks = 0;

  // Input source control: DOUT mode 0 = constant, 1 = SEL pattern, 2 = random.
  int          dmode = 0;
  logic [6:0]  dconst = 7'h7F;
  logic [20:0] saff_val = 21'd0;
  bit          saff_rand = 1'b0;

  always #5 clk = ~clk;

  sequencer_for_tdc_v1_sw_28_10_19 dut (
    .clk            (clk),
    .reset          (reset),
    .run_sequencer  (run_sequencer),
    .t_start_coarse (t_start_coarse),
    .t_stop_coarse  (t_stop_coarse),
    .ready_flag     (ready_flag),
    .measure_flag   (measure_flag),
    .write          (write),
    .data           (data),
    .SEL            (SEL),
    .PSTART         (PSTART),
    .PSTOP          (PSTOP),
    .RES            (RES),
    .DOUT           (DOUT),
    .SAFF           (SAFF)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] s);
    return {s[2:0], s} ^ 7'h55;
  endfunction

  // Chip-side inputs change only between rising edges.
  always @(negedge clk) begin
    case (dmode)
      0:       DOUT = dconst;
      1:       DOUT = pat(SEL);
      default: DOUT = 7'($urandom);
    endcase
    SAFF = saff_rand ? 21'($urandom) : saff_val;
  end

  // ---------------- behavioural model: outputs as a function of the
  // cycle index n (1..311) since the run was accepted ----------------
  localparam int R0 = 1 + 4 + 256 + 1;   // first readout cycle
  localparam int NW = 16 * 3;            // readout cycles

  bit          m_busy = 1'b0;
  int          m_n = 0;
  logic [7:0]  m_ts = 8'd0, m_tp = 8'd0;
  logic [20:0] m_saff = 21'd0;
  logic [15:0] m_data = 16'd0;

  int cyc = 0, accept_cyc = 0, ready_rise_cyc = 0;
  int pstart_rise_n = -1, pstop_rise_n = -1, pstart_fall_n = -1;
  bit prev_ready = 1'b1, prev_pstart = 1'b0, prev_pstop = 1'b0;
  logic [15:0] words[$];

  always @(posedge clk) begin : model
    int   i, c;
    logic e_rd, e_wr, e_meas;
    logic [3:0] e_sel;
    cyc++;
    if (reset) begin
      m_busy = 1'b0; m_n = 0; m_data = 16'd0;
    end else if (!m_busy) begin
      if (run_sequencer) begin
        m_busy = 1'b1; m_n = 1; m_ts = t_start_coarse; m_tp = t_stop_coarse;
        accept_cyc = cyc;
      end
    end else begin
      m_n++;
      if (m_n == R0) m_saff = SAFF;
      if (m_n == 312) begin m_busy = 1'b0; m_n = 0; end
    end
    i      = m_n - R0;
    e_rd   = m_busy && (i >= 0) && (i < NW);
    e_wr   = (e_rd && (i % 3 == 2)) || (m_busy && (i == NW || i == NW + 1));
    e_sel  = e_rd ? 4'(i / 3) : 4'd0;
    if (e_rd && (i % 3 == 2))   m_data = {1'b0, 4'(i / 3), 4'b0000, DOUT};
    else if (m_busy && i == NW) m_data = {2'b10, m_saff[13:0]};
    else if (m_busy && i == NW + 1) m_data = {2'b11, 7'b0, m_saff[20:14]};
    e_meas = m_busy && (m_n >= 5) && (m_n <= 260);
    c      = m_n - 5;
    #1;
    chk("ready_flag",   32'(ready_flag),   32'(!m_busy));
    chk("RES",          32'(RES),          32'(m_busy && m_n >= 1 && m_n <= 4));
    chk("measure_flag", 32'(measure_flag), 32'(e_meas));
    chk("PSTART",       32'(PSTART),       32'(e_meas && c >= int'(m_ts)));
    chk("PSTOP",        32'(PSTOP),        32'(e_meas && c >= int'(m_tp)));
    chk("SEL",          32'(SEL),          32'(e_sel));
    chk("write",        32'(write),        32'(e_wr));
    chk("data",         32'(data),         32'(m_data));
    if (write) words.push_back(data);
    if (ready_flag && !prev_ready) ready_rise_cyc = cyc;
    if (PSTART && !prev_pstart) pstart_rise_n = m_n;
    if (!PSTART && prev_pstart) pstart_fall_n = m_n;
    if (PSTOP && !prev_pstop) pstop_rise_n = m_n;
    prev_ready = ready_flag; prev_pstart = PSTART; prev_pstop = PSTOP;
  end

  task automatic pulse_run();
    @(negedge clk); run_sequencer = 1'b1;
    @(negedge clk); run_sequencer = 1'b0;
  endtask

  task automatic wait_ready(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ready_flag) return;
    end
    checks++; errors++;
    $display("FAIL ready timeout: ready_flag still 0 after %0d cycles", limit);
  endtask

  initial begin : stim
    int base;
    logic [15:0] run2[$];
    int r2_rise, r2_stop;
    bit hit;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Run 1: thresholds 0, DOUT all ones, SAFF zero.
    base = words.size();
    pulse_run();
    wait_ready(400);
    chk("run1 word count", 32'(words.size() - base), 32'd18);
    chk("run1 word0",  32'(words[base]),      32'h007F);
    chk("run1 word1",  32'(words[base + 1]),  32'h087F);
    chk("run1 word15", 32'(words[base + 15]), 32'h787F);
    chk("run1 saff lo", 32'(words[base + 16]), 32'h8000);
    chk("run1 saff hi", 32'(words[base + 17]), 32'hC000);
    chk("run1 pstart rise n", 32'(pstart_rise_n), 32'd5);
    chk("run1 pstop rise n",  32'(pstop_rise_n),  32'd5);
    chk("run1 ready latency", 32'(ready_rise_cyc - accept_cyc), 32'd311);

    // Run 2: 10/200, SAFF all ones, SEL-dependent DOUT, threshold change and
    // run pulse mid-run.
    base = words.size();
    t_start_coarse = 8'd10; t_stop_coarse = 8'd200;
    saff_val = 21'h1FFFFF; dmode = 1;
    pulse_run();
    t_start_coarse = 8'd50; t_stop_coarse = 8'd60;
    repeat (100) @(negedge clk);
    run_sequencer = 1'b1; @(negedge clk); run_sequencer = 1'b0;
    wait_ready(400);
    chk("run2 word count", 32'(words.size() - base), 32'd18);
    chk("run2 pstart rise n", 32'(pstart_rise_n), 32'd15);
    chk("run2 pstop rise n",  32'(pstop_rise_n),  32'd205);
    chk("run2 pstart fall n", 32'(pstart_fall_n), 32'd261);
    chk("run2 word0",  32'(words[base]),      32'h0055);
    chk("run2 word5",  32'(words[base + 5]),  32'h2800);
    chk("run2 word15", 32'(words[base + 15]), 32'h782A);
    for (int k = 0; k < 16; k++)
      chk("run2 dout field", 32'(words[base + k]), 32'({1'b0, 4'(k), 4'b0000, pat(4'(k))}));
    chk("run2 saff lo", 32'(words[base + 16]), 32'hBFFF);
    chk("run2 saff hi", 32'(words[base + 17]), 32'hC07F);
    chk("run2 ready latency", 32'(ready_rise_cyc - accept_cyc), 32'd311);
    for (int k = 0; k < 18; k++) run2.push_back(words[base + k]);
    r2_rise = pstart_rise_n; r2_stop = pstop_rise_n;

    // Run 3: same setup 1000 cycles later must repeat run 2 exactly.
    repeat (1000) @(negedge clk);
    t_start_coarse = 8'd10; t_stop_coarse = 8'd200;
    base = words.size();
    pulse_run();
    wait_ready(400);
    chk("run3 word count", 32'(words.size() - base), 32'd18);
    for (int k = 0; k < 18; k++)
      chk("run3 word vs run2", 32'(words[base + k]), 32'(run2[k]));
    chk("run3 pstart rise n", 32'(pstart_rise_n), 32'(r2_rise));
    chk("run3 pstop rise n",  32'(pstop_rise_n),  32'(r2_stop));

    // Reset during READ aborts the run at once.
    pulse_run();
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (m_n == 280) hit = 1'b1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL read phase timeout: model never reached readout");
    end
    reset = 1'b1;
    #1;
    chk("abort ready_flag", 32'(ready_flag), 32'd1);
    chk("abort write",  32'(write),  32'd0);
    chk("abort SEL",    32'(SEL),    32'd0);
    chk("abort RES",    32'(RES),    32'd0);
    chk("abort PSTART", 32'(PSTART), 32'd0);
    chk("abort PSTOP",  32'(PSTOP),  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Random runs: random thresholds (first one pinned at 255), random chip
    // inputs every cycle, random run requests throughout.
    saff_rand = 1'b1; dmode = 2;
    for (int r = 0; r < 6; r++) begin
      t_start_coarse = (r == 0) ? 8'd255 : 8'($urandom);
      t_stop_coarse  = (r == 0) ? 8'd255 : 8'($urandom);
      pulse_run();
      for (int i = 0; i < 700; i++) begin
        @(negedge clk);
        run_sequencer = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) begin
          t_start_coarse = 8'($urandom);
          t_stop_coarse  = 8'($urandom);
        end
      end
      run_sequencer = 1'b0;
      wait_ready(400);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
